// File: rtl/vmul_pkg.sv
// Shared types and constants for the radix-4 Booth partial-product front end.
package vmul_pkg;

   localparam int NUM_PP = 18;

   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } booth_digit_e;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DONE
   } state_e;

   function automatic int row_lsb(input int k, input int pw);
      return k * pw;
   endfunction

endpackage

// File: rtl/booth_r4_row.sv
// One radix-4 Booth partial-product row: decode a multiplier triplet, select
// 0/A/2A, one's-complement for negative digits and place the row at 2*idx.
module booth_r4_row
   import vmul_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PW   = 2 * XLEN,
   parameter int IW   = 5
) (
   input  logic [2:0]      trip,
   input  logic [XLEN:0]   a_ext,
   input  logic [IW-1:0]   idx,
   output logic [PW-1:0]   row,
   output logic            neg
);

   booth_digit_e    digit;
   logic [XLEN+1:0] mag;
   logic [XLEN+1:0] mag_c;

   always_comb begin
      digit = ZERO;
      case (trip)
         3'b001, 3'b010: digit = POS1;
         3'b011:         digit = POS2;
         3'b100:         digit = NEG2;
         3'b101, 3'b110: digit = NEG1;
         default:        digit = ZERO;
      endcase

      mag = '0;
      case (digit)
         POS1, NEG1: mag = {a_ext[XLEN], a_ext};
         POS2, NEG2: mag = {a_ext, 1'b0};
         default:    mag = '0;
      endcase

      // The +1 that completes the negation is carried by the correction row.
      neg   = (digit == NEG1) || (digit == NEG2);
      mag_c = neg ? ~mag : mag;
      row   = {{(PW-XLEN-2){mag_c[XLEN+1]}}, mag_c} << {idx, 1'b0};
   end

endmodule

// File: rtl/vmul_booth_issue.sv
// Booth radix-4 row issue stage: registers 18 rows for the Wallace adder and
// tracks the adder's single register stage to issue an aligned valid/tag.
module vmul_booth_issue
   import vmul_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PW   = 2 * XLEN,
   parameter int TAGW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_a,
   input  logic [XLEN-1:0]      in_b,
   input  logic                 in_a_signed,
   input  logic                 in_b_signed,
   input  logic [TAGW-1:0]      in_tag,
   output logic [NUM_PP*PW-1:0] pp_row,
   output logic                 sum_valid,
   input  logic                 sum_ready,
   output logic [TAGW-1:0]      sum_tag
);

   localparam int NDIG = XLEN / 2 + 1;
   localparam int IW   = $clog2(NDIG);

   state_e                state_q, state_d;
   logic [NUM_PP*PW-1:0]  rows_q, rows_d, rows_new;
   logic [TAGW-1:0]       tag_q, tag_d;
   logic                  load;

   logic [XLEN:0]         a_ext;
   logic [XLEN+2:0]       b_trip;
   logic [PW-1:0]         row_w [NDIG];
   logic                  neg_w [NDIG];
   logic [PW-1:0]         neg_row;

   assign a_ext  = {in_a_signed & in_a[XLEN-1], in_a};
   // Extended multiplier with the implicit b[-1]=0 appended at the bottom.
   assign b_trip = {{2{in_b_signed & in_b[XLEN-1]}}, in_b, 1'b0};

   for (genvar i = 0; i < NDIG; i++) begin : g_row
      booth_r4_row #(
         .XLEN (XLEN),
         .PW   (PW),
         .IW   (IW)
      ) u_row (
         .trip  (b_trip[2*i +: 3]),
         .a_ext (a_ext),
         .idx   (IW'(i)),
         .row   (row_w[i]),
         .neg   (neg_w[i])
      );
   end

   always_comb begin
      neg_row = '0;
      for (int i = 0; i < NDIG; i++) begin
         neg_row = neg_row | (PW'(neg_w[i]) << (2 * i));
      end
      rows_new = '0;
      for (int k = 0; k < NDIG; k++) begin
         rows_new[row_lsb(k, PW) +: PW] = row_w[k];
      end
      rows_new[row_lsb(NUM_PP-1, PW) +: PW] = neg_row;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = SETTLE;
         end
         SETTLE: begin
            state_d = DONE;
         end
         DONE: begin
            in_ready = sum_ready;
            if (sum_ready) state_d = in_valid ? SETTLE : IDLE;
         end
         default: state_d = IDLE;
      endcase
      load   = in_valid && in_ready;
      rows_d = load ? rows_new : rows_q;
      tag_d  = load ? in_tag : tag_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rows_q  <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         rows_q  <= rows_d;
         tag_q   <= tag_d;
      end
   end

   assign pp_row    = rows_q;
   assign sum_tag   = tag_q;
   assign sum_valid = (state_q == DONE);

endmodule

// File: tb/tb_vmul_booth_issue.sv
// Randomised bench for vmul_booth_issue with an adder model and a product scoreboard.
module tb_vmul_booth_issue;

   localparam int XLEN = 32;
   localparam int PW   = 64;
   localparam int TAGW = 8;
   localparam int NPP  = 18;

   typedef struct {
      longint unsigned acc;
      logic [TAGW-1:0] tag;
      logic [63:0]     prod;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [XLEN-1:0]     in_a;
   logic [XLEN-1:0]     in_b;
   logic                in_a_signed;
   logic                in_b_signed;
   logic [TAGW-1:0]     in_tag;
   logic [NPP*PW-1:0]   pp_row;
   logic                sum_valid;
   logic                sum_ready;
   logic [TAGW-1:0]     sum_tag;

   int                  checks   = 0;
   int                  failures = 0;
   int                  n_acc    = 0;
   longint unsigned     cyc      = 0;
   logic                chk_en   = 1'b0;
   logic [63:0]         adder_q  = '0;
   exp_t                q[$];

   vmul_booth_issue #(.XLEN(XLEN), .PW(PW), .TAGW(TAGW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_a_signed (in_a_signed),
      .in_b_signed (in_b_signed),
      .in_tag      (in_tag),
      .pp_row      (pp_row),
      .sum_valid   (sum_valid),
      .sum_ready   (sum_ready),
      .sum_tag     (sum_tag)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] row_sum(input logic [NPP*PW-1:0] r);
      logic [63:0] s = '0;
      for (int k = 0; k < NPP; k++) s = s + r[k*PW +: PW];
      return s;
   endfunction

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb);
      logic [63:0] ea, eb;
      ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
      eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Downstream adder: one free-running register on the sum of all rows.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      adder_q <= row_sum(pp_row);
   end

   logic exp_v, exp_rdy;
   exp_t e_new;
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         exp_v   = (q.size() > 0) && (cyc >= q[0].acc + 1);
         exp_rdy = (q.size() == 0) ? 1'b1 : (exp_v ? sum_ready : 1'b0);
         check("sum_valid", 64'(sum_valid), 64'(exp_v));
         check("in_ready", 64'(in_ready), 64'(exp_rdy));
         if (exp_v) begin
            check("sum_tag", 64'(sum_tag), 64'(q[0].tag));
            check("adder_sum", adder_q, q[0].prod);
            if (sum_ready) void'(q.pop_front());
         end
         if (in_valid && exp_rdy) begin
            e_new.acc  = cyc + 1;
            e_new.tag  = in_tag;
            e_new.prod = ref_mul(in_a, in_b, in_a_signed, in_b_signed);
            q.push_back(e_new);
            n_acc++;
         end
      end
   end

   task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic sa,
                           input logic sb, input logic [7:0] tag, input logic [63:0] exp,
                           input string name);
      int lat;
      @(posedge clk); #1;
      in_a = a; in_b = b; in_a_signed = sa; in_b_signed = sb; in_tag = tag;
      in_valid = 1'b1; sum_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({name, " rows_sum"}, row_sum(pp_row), exp);
      lat = 10;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (sum_valid) begin
            lat = i;
            break;
         end
      end
      check({name, " latency"}, 64'(lat), 64'd1);
      check({name, " product"}, adder_q, exp);
      check({name, " tag"}, 64'(sum_tag), 64'(tag));
      @(posedge clk); #1;
   endtask

   logic [NPP*PW-1:0] snap;
   int                found;
   int                sel;

   function automatic logic [31:0] pick_operand();
      sel = $urandom_range(0, 7);
      case (sel)
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_a_signed = 1'b0; in_b_signed = 1'b0;
      in_tag = '0; sum_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset pp_row zero", 64'(pp_row == '0), 64'd1);
      check("reset sum_valid", 64'(sum_valid), 64'd0);
      check("reset sum_tag", 64'(sum_tag), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      chk_en = 1'b1;

      directed(32'd3, 32'd5, 1'b0, 1'b0, 8'h11, 64'h0000_0000_0000_000F, "basic");
      directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 8'h22, 64'h0000_0000_0000_0001, "ss_m1");
      directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h33, 64'hFFFF_FFFE_0000_0001, "uu_max");
      directed(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 8'h44, 64'h4000_0000_0000_0000, "ss_min");
      directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 8'h55, 64'hFFFF_FFFF_0000_0001, "su_mix");

      // Backpressure with a second operation waiting.
      @(posedge clk); #1;
      sum_ready = 1'b0; in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      in_a_signed = 1'b1; in_b_signed = 1'b0; in_tag = 8'h5A;
      @(posedge clk); #1;
      in_a = $urandom; in_b = $urandom; in_tag = 8'hA5;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (sum_valid) begin
            found = 1;
            break;
         end
      end
      check("bp valid reached", 64'(found), 64'd1);
      snap = pp_row;
      repeat (5) begin
         @(negedge clk);
         check("bp sum_valid held", 64'(sum_valid), 64'd1);
         check("bp sum_tag held", 64'(sum_tag), 64'h5A);
         check("bp pp_row held", 64'(pp_row == snap), 64'd1);
         check("bp in_ready low", 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;
      sum_ready = 1'b1;
      @(negedge clk);
      check("bp release in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp settle sum_valid", 64'(sum_valid), 64'd0);
      @(negedge clk);
      check("bp next sum_valid", 64'(sum_valid), 64'd1);
      check("bp next tag", 64'(sum_tag), 64'hA5);
      repeat (2) @(posedge clk);

      // Reset while the operation is in SETTLE.
      #1;
      in_valid = 1'b1; in_a = 32'd7; in_b = 32'd9; in_tag = 8'h77; sum_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      rst = 1'b1;
      chk_en = 1'b0;
      q.delete();
      #1;
      check("async rst pp_row", 64'(pp_row == '0), 64'd1);
      check("async rst sum_valid", 64'(sum_valid), 64'd0);
      check("async rst sum_tag", 64'(sum_tag), 64'd0);
      check("async rst in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
      check("post rst in_ready", 64'(in_ready), 64'd1);
      repeat (6) begin
         @(negedge clk);
         check("discarded op no valid", 64'(sum_valid), 64'd0);
      end

      // Random traffic against the scoreboard.
      found = n_acc + 10000;
      for (int c = 0; c < 60000 && n_acc < found; c++) begin
         @(posedge clk); #1;
         in_valid    = ($urandom_range(0, 3) != 0);
         in_a        = pick_operand();
         in_b        = pick_operand();
         in_a_signed = 1'($urandom_range(0, 1));
         in_b_signed = 1'($urandom_range(0, 1));
         in_tag      = 8'($urandom);
         sum_ready   = ($urandom_range(0, 3) != 0);
      end
      check("random ops done", 64'(n_acc >= found), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; sum_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("drain empty", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
